// File: rtl/sseg_page_scheduler.sv
// sseg_page_scheduler
// Picks which 32-bit source word is shown on the 8-digit seven-segment display.
// Rotates round-robin over the valid sources on a dwell timer. Also supports a
// manual next-page advance, a rotation hold, and a pin override that locks the
// display to one source. All outputs are registered.
module sseg_page_scheduler #(
    parameter int  NUM_SRC      = 4,
    parameter int  DWELL_CYCLES = 100_000_000,
    localparam int SW           = $clog2(NUM_SRC),
    localparam int CW           = $clog2(DWELL_CYCLES)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [32*NUM_SRC-1:0]  SRC_VALUE,
    input  logic [NUM_SRC-1:0]     SRC_VALID,
    input  logic                   NEXT_PAGE,
    input  logic                   HOLD,
    input  logic                   PIN_REQ,
    input  logic [SW-1:0]          PIN_SEL,
    output logic [31:0]            VALUE,
    output logic [SW-1:0]          PAGE,
    output logic                   PAGE_VALID,
    output logic                   PAGE_TICK
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_PINNED = 2'd2;

    logic [1:0]    state;
    logic [1:0]    nxt_state;
    logic [SW-1:0] nxt_page;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          pin_ok;
    logic          any_valid;
    logic          dwell_end;
    logic [31:0]   src_word [NUM_SRC];

    // First valid index strictly after cur, wrapping; cur itself is the last candidate.
    function automatic logic [SW-1:0] next_valid(input logic [SW-1:0] cur,
                                                 input logic [NUM_SRC-1:0] vld);
        logic [SW-1:0] res;
        int            idx;
        res = cur;
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            idx = (int'(cur) + k) % NUM_SRC;
            if (vld[SW'(idx)]) res = SW'(idx);
        end
        return res;
    endfunction

    // Lowest-index valid source (0 when none is valid).
    function automatic logic [SW-1:0] lowest_valid(input logic [NUM_SRC-1:0] vld);
        logic [SW-1:0] res;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (vld[SW'(k)]) res = SW'(k);
        end
        return res;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_word[i] = SRC_VALUE[32*i +: 32];
    end

    assign any_valid = |SRC_VALID;
    assign pin_ok    = PIN_REQ && (int'(PIN_SEL) < NUM_SRC) && SRC_VALID[PIN_SEL];
    assign dwell_end = (cnt == CW'(DWELL_CYCLES - 1));

    // Next state, page and dwell count from the current mode and inputs.
    always_comb begin
        nxt_state = state;
        nxt_page  = PAGE;
        nxt_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                nxt_cnt = '0;
                if (pin_ok) begin
                    nxt_state = ST_PINNED;
                    nxt_page  = PIN_SEL;
                end else if (any_valid) begin
                    nxt_state = ST_SHOW;
                    nxt_page  = lowest_valid(SRC_VALID);
                end
            end
            ST_SHOW: begin
                if (pin_ok) begin
                    nxt_state = ST_PINNED;
                    nxt_page  = PIN_SEL;
                    nxt_cnt   = '0;
                end else if (!any_valid) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end else if ((dwell_end && !HOLD) || NEXT_PAGE || !SRC_VALID[PAGE]) begin
                    // Expiry and a manual pulse together still yield a single step.
                    nxt_page = next_valid(PAGE, SRC_VALID);
                    nxt_cnt  = '0;
                end else if (!HOLD) begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            ST_PINNED: begin
                nxt_cnt = '0;
                if (pin_ok) begin
                    nxt_page = PIN_SEL;
                end else if (!any_valid) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_state = ST_SHOW;
                    if (!SRC_VALID[PAGE]) nxt_page = next_valid(PAGE, SRC_VALID);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Register mode, counter and all display outputs; VALUE follows the next page.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            PAGE       <= '0;
            VALUE      <= '0;
            PAGE_VALID <= 1'b0;
            PAGE_TICK  <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            PAGE       <= nxt_page;
            VALUE      <= (nxt_state == ST_IDLE) ? 32'd0 : src_word[nxt_page];
            PAGE_VALID <= (nxt_state != ST_IDLE) && SRC_VALID[nxt_page];
            PAGE_TICK  <= (nxt_state != ST_IDLE) &&
                          ((state == ST_IDLE) || (nxt_page != PAGE));
        end
    end

endmodule

// File: tb/tb_sseg_page_scheduler.sv
// Bench for sseg_page_scheduler: directed stimulus, a behavioural model of
// the page rules checked every cycle, plus literal expectations at key points.
module tb_sseg_page_scheduler;

    localparam int NSRC = 4;
    localparam int DW   = 8;
    localparam int M_IDLE = 0, M_ROT = 1, M_PIN = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  src_word [NSRC];
    logic [127:0] src_value;
    logic [3:0]   src_valid = 4'b0000;
    logic         next_page = 1'b0;
    logic         hold = 1'b0;
    logic         pin_req = 1'b0;
    logic [1:0]   pin_sel = 2'd0;
    logic [31:0]  value;
    logic [1:0]   page;
    logic         page_valid;
    logic         page_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_mode = M_IDLE;
    logic [1:0]  m_page = 2'd0;
    int          m_elapsed = 0;
    logic [31:0] e_value = 32'd0;
    logic [1:0]  e_page = 2'd0;
    logic        e_pv = 1'b0;
    logic        e_tick = 1'b0;

    assign src_value = {src_word[3], src_word[2], src_word[1], src_word[0]};

    sseg_page_scheduler #(.NUM_SRC(NSRC), .DWELL_CYCLES(DW)) dut (
        .CLK(clk), .RST(rst), .SRC_VALUE(src_value), .SRC_VALID(src_valid),
        .NEXT_PAGE(next_page), .HOLD(hold), .PIN_REQ(pin_req), .PIN_SEL(pin_sel),
        .VALUE(value), .PAGE(page), .PAGE_VALID(page_valid), .PAGE_TICK(page_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Round-robin choice: smallest valid index above p, else smallest valid overall.
    function automatic logic [1:0] after_page(input logic [1:0] p, input logic [3:0] v);
        int best;
        best = -1;
        for (int k = 0; k < NSRC; k++)
            if (best < 0 && v[2'(k)] && k > int'(p)) best = k;
        for (int k = 0; k < NSRC; k++)
            if (best < 0 && v[2'(k)]) best = k;
        return (best < 0) ? p : 2'(best);
    endfunction

    function automatic logic [1:0] first_page(input logic [3:0] v);
        return after_page(2'd3, v);
    endfunction

    // Predict the outputs after the coming rising edge from the inputs now applied.
    task automatic model_edge();
        int         nm;
        logic [1:0] np;
        logic       pok;
        logic       any;
        if (rst) begin
            m_mode = M_IDLE; m_page = 2'd0; m_elapsed = 0;
            e_value = 32'd0; e_page = 2'd0; e_pv = 1'b0; e_tick = 1'b0;
            return;
        end
        any = |src_valid;
        pok = pin_req && src_valid[pin_sel];
        nm  = m_mode;
        np  = m_page;
        if (m_mode == M_IDLE) begin
            m_elapsed = 0;
            if (pok) begin nm = M_PIN; np = pin_sel; end
            else if (any) begin nm = M_ROT; np = first_page(src_valid); end
        end else if (m_mode == M_ROT) begin
            if (pok) begin nm = M_PIN; np = pin_sel; m_elapsed = 0; end
            else if (!any) begin nm = M_IDLE; m_elapsed = 0; end
            else if ((m_elapsed + 1 >= DW && !hold) || next_page || !src_valid[m_page]) begin
                np = after_page(m_page, src_valid);
                m_elapsed = 0;
            end else if (!hold) m_elapsed++;
        end else begin
            m_elapsed = 0;
            if (pok) np = pin_sel;
            else if (!any) nm = M_IDLE;
            else begin
                nm = M_ROT;
                if (!src_valid[m_page]) np = after_page(m_page, src_valid);
            end
        end
        e_tick  = (nm != M_IDLE) && (m_mode == M_IDLE || np != m_page);
        m_mode  = nm;
        m_page  = np;
        e_page  = np;
        e_pv    = (nm != M_IDLE) && src_valid[np];
        e_value = (nm == M_IDLE) ? 32'd0 : src_word[np];
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(negedge clk);
            chk("model_value", value, e_value);
            chk("model_page", 32'(page), 32'(e_page));
            chk("model_page_valid", 32'(page_valid), 32'(e_pv));
            chk("model_page_tick", 32'(page_tick), 32'(e_tick));
        end
    endtask

    task automatic pulse_next();
        next_page = 1'b1;
        step(1);
        next_page = 1'b0;
    endtask

    task automatic lit(input string name, input logic [1:0] p, input logic [31:0] v,
                       input logic pv, input logic tk);
        chk({name, "_page"}, 32'(page), 32'(p));
        chk({name, "_value"}, value, v);
        chk({name, "_pv"}, 32'(page_valid), 32'(pv));
        chk({name, "_tick"}, 32'(page_tick), 32'(tk));
    endtask

    initial begin
        for (int i = 0; i < NSRC; i++) src_word[i] = 32'h11111111 * i;

        // Reset, then nothing valid: stays idle
        step(2);
        lit("reset", 2'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step(20);
        lit("idle", 2'd0, 32'h0, 1'b0, 1'b0);

        // Timed rotation over 1011: pages 0,1,3,0 with 8 cycles each
        src_valid = 4'b1011;
        step(1);
        lit("rot0", 2'd0, 32'h00000000, 1'b1, 1'b1);
        step(7);
        lit("rot0_end", 2'd0, 32'h00000000, 1'b1, 1'b0);
        step(1);
        lit("rot1", 2'd1, 32'h11111111, 1'b1, 1'b1);
        step(8);
        lit("rot3", 2'd3, 32'h33333333, 1'b1, 1'b1);
        step(8);
        lit("rot_wrap", 2'd0, 32'h00000000, 1'b1, 1'b1);

        // Hold mid-page freezes the dwell
        step(3);
        hold = 1'b1;
        step(20);
        hold = 1'b0;
        step(4);
        lit("hold_remain", 2'd0, 32'h00000000, 1'b1, 1'b0);
        step(1);
        lit("hold_done", 2'd1, 32'h11111111, 1'b1, 1'b1);

        // Manual advance while held
        hold = 1'b1;
        step(2);
        pulse_next();
        lit("next_in_hold", 2'd3, 32'h33333333, 1'b1, 1'b1);
        hold = 1'b0;

        // Manual advance coinciding with dwell expiry: exactly one step
        src_valid = 4'b1111;
        pulse_next();
        pulse_next();
        lit("at_page1", 2'd1, 32'h11111111, 1'b1, 1'b1);
        step(7);
        pulse_next();
        lit("coincide", 2'd2, 32'h22222222, 1'b1, 1'b1);
        step(1);
        lit("coincide_after", 2'd2, 32'h22222222, 1'b1, 1'b0);

        // Pin override
        pulse_next();
        pin_req = 1'b1; pin_sel = 2'd2;
        step(1);
        lit("pin2", 2'd2, 32'h22222222, 1'b1, 1'b1);
        pulse_next();
        step(50);
        lit("pin2_held", 2'd2, 32'h22222222, 1'b1, 1'b0);
        pin_sel = 2'd0;
        step(1);
        lit("pin_move", 2'd0, 32'h00000000, 1'b1, 1'b1);
        pin_sel = 2'd2;
        step(1);
        src_valid = 4'b1011;
        step(1);
        lit("pin_lost", 2'd3, 32'h33333333, 1'b1, 1'b1);
        pin_req = 1'b0;
        step(1);
        lit("unpin", 2'd3, 32'h33333333, 1'b1, 1'b0);

        // Reset while pinned on page 3, then re-entry at lowest valid index
        pin_req = 1'b1; pin_sel = 2'd3;
        step(3);
        rst = 1'b1; pin_req = 1'b0; src_valid = 4'b1010;
        step(1);
        lit("reset_pinned", 2'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        lit("reentry", 2'd1, 32'h11111111, 1'b1, 1'b1);

        // Live data tracking and loss of all sources
        src_word[1] = 32'hDEADBEEF;
        step(1);
        lit("live", 2'd1, 32'hDEADBEEF, 1'b1, 1'b0);
        src_valid = 4'b0000;
        step(1);
        lit("all_lost", 2'd1, 32'h0, 1'b0, 1'b0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
